// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM encoding and default bus widths for the APB master arbiter
package apb_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
endpackage

// File: rtl/apb_master_arbiter_if.sv
// apb_master_arbiter_if: requester-side and APB-side signals of the arbiter
//   requester side: req, req_write, req_addr, req_wdata -> gnt, done, rsp_rdata, rsp_err
//   APB side: psel, penable, pwrite, paddr, pwdata -> pready, pslverr, prdata
//   master modport is the arbiter's view, slave modport the clients'/slave's view
interface apb_master_arbiter_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();
    logic [1:0]          req;
    logic [1:0]          req_write;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          gnt;
    logic [1:0]          done;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_err;
    logic                psel;
    logic                penable;
    logic                pwrite;
    logic [ADDR_W-1:0]   paddr;
    logic [DATA_W-1:0]   pwdata;
    logic                pready;
    logic                pslverr;
    logic [DATA_W-1:0]   prdata;
    modport master (
        input  req, req_write, req_addr, req_wdata, pready, pslverr, prdata,
        output gnt, done, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
    );
    modport slave (
        output req, req_write, req_addr, req_wdata, pready, pslverr, prdata,
        input  gnt, done, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_rr_pick.sv
// apb_rr_pick: combinational 2-way round-robin chooser
//   req_i  : per-requester request
//   last_i : index of the last granted requester
//   pick_o : one-hot winner (zero when nobody requests)
module apb_rr_pick (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] pick_o
);
    always_comb pick_o = (&req_i) ? (last_i ? 2'b01 : 2'b10) : req_i;
endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: two-requester round-robin APB master with wait-state timeout
//   pclk, preset : clock, synchronous active-high reset
//   bus_if       : requester handshake and APB bus (master modport)
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 16
) (
    input logic                  pclk,
    input logic                  preset,
    apb_master_arbiter_if.master bus_if
);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    apb_state_e        state_q, state_d;
    logic [1:0]        gnt_q, gnt_d, done_q, done_d, pick;
    logic [DATA_W-1:0] rdata_q, rdata_d, pwdata_q, pwdata_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              err_q, err_d, psel_q, psel_d, penable_q, penable_d;
    logic              pwrite_q, pwrite_d, last_q, last_d;
    logic [TW-1:0]     wait_q, wait_d;
    logic              start, finish, timeout_hit, win;

    apb_rr_pick u_pick (
        .req_i (bus_if.req),
        .last_i(last_q),
        .pick_o(pick)
    );

    assign win = pick[1];
    // The done cycle is the turnaround: requests are not sampled while done is high.
    assign start = (state_q == IDLE) && (done_q == 2'b00) && (|bus_if.req);
    assign timeout_hit = (TIMEOUT != 0) && !bus_if.pready && (wait_q == TW'(TIMEOUT - 1));
    assign finish = (state_q == ACCESS) && (bus_if.pready || timeout_hit);

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            done_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            last_q    <= 1'b1;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            last_q    <= last_d;
            wait_q    <= wait_d;
        end
    end

    always_comb begin
        state_d = start ? SETUP : (state_q == SETUP) ? ACCESS : finish ? IDLE : state_q;
    end

    always_comb begin
        gnt_d     = start ? pick : finish ? 2'b00 : gnt_q;
        done_d    = finish ? gnt_q : 2'b00;
        rdata_d   = finish ? ((bus_if.pready && !pwrite_q) ? bus_if.prdata : '0) : rdata_q;
        err_d     = finish ? (bus_if.pready ? bus_if.pslverr : 1'b1) : err_q;
        psel_d    = state_d != IDLE;
        penable_d = state_d == ACCESS;
        pwrite_d  = start ? bus_if.req_write[win] : pwrite_q;
        paddr_d   = start ? (win ? bus_if.req_addr[2*ADDR_W-1:ADDR_W] : bus_if.req_addr[ADDR_W-1:0]) : paddr_q;
        pwdata_d  = start ? (win ? bus_if.req_wdata[2*DATA_W-1:DATA_W] : bus_if.req_wdata[DATA_W-1:0]) : pwdata_q;
        last_d    = start ? win : last_q;
        // Counts stalled ACCESS cycles; any other state (incl. SETUP) clears it for the next ACCESS.
        wait_d    = ((state_q == ACCESS) && !bus_if.pready) ? wait_q + TW'(1) : '0;
    end

    assign bus_if.gnt       = gnt_q;
    assign bus_if.done      = done_q;
    assign bus_if.rsp_rdata = rdata_q;
    assign bus_if.rsp_err   = err_q;
    assign bus_if.psel      = psel_q;
    assign bus_if.penable   = penable_q;
    assign bus_if.pwrite    = pwrite_q;
    assign bus_if.paddr     = paddr_q;
    assign bus_if.pwdata    = pwdata_q;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: randomized transaction-level check of apb_master_arbiter
module tb_apb_master_arbiter;
    localparam int TO = 4;

    logic pclk = 1'b0;
    logic preset = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;
    logic last_w = 1'b1;
    logic prev_done = 1'b0;

    always #5 pclk = ~pclk;

    apb_master_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_master_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .pclk  (pclk),
        .preset(preset),
        .bus_if(bus.master)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(negedge pclk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_gnt"}, bus.gnt, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_psel"}, bus.psel, 0);
        chk({tag, "_penable"}, bus.penable, 0);
        chk({tag, "_pwrite"}, bus.pwrite, 0);
        chk({tag, "_paddr"}, bus.paddr, 0);
        chk({tag, "_pwdata"}, bus.pwdata, 0);
        chk({tag, "_rdata"}, bus.rsp_rdata, 0);
        chk({tag, "_err"}, bus.rsp_err, 0);
    endtask

    // One full transfer from request to done pulse, predicted from the arbitration and APB rules.
    task automatic xfer(input logic [1:0] mask, input logic [1:0] wr, input logic [63:0] addrs,
                        input logic [63:0] wdatas, input int waits, input logic slverr,
                        input logic [31:0] rd);
        logic        w;
        logic [31:0] a, d;
        int          n, k, exp_acc;
        bit          tmo;
        bus.req       = mask;
        bus.req_write = wr;
        bus.req_addr  = addrs;
        bus.req_wdata = wdatas;
        bus.pready    = 1'($urandom);
        w = (mask == 2'b11) ? ~last_w : mask[1];
        last_w = w;
        a = w ? addrs[63:32] : addrs[31:0];
        d = w ? wdatas[63:32] : wdatas[31:0];
        n = 0;
        do begin
            step();
            n++;
            if (n == 1) chk("done_one_cycle", bus.done, 0);
        end while (bus.gnt == 2'b00 && n < 4);
        chk("grant_latency", n, prev_done ? 2 : 1);
        chk("gnt", bus.gnt, 2'b01 << w);
        chk("setup_psel", bus.psel, 1);
        chk("setup_penable", bus.penable, 0);
        chk("setup_paddr", bus.paddr, a);
        chk("setup_pwrite", bus.pwrite, wr[w]);
        chk("setup_pwdata", bus.pwdata, d);
        bus.req_write = ~wr;
        bus.req_addr  = {$urandom, $urandom};
        bus.req_wdata = {$urandom, $urandom};
        bus.pready    = 1'($urandom);
        tmo = (waits >= TO);
        exp_acc = tmo ? TO : waits + 1;
        k = 0;
        step();
        while (bus.done == 2'b00 && k < 20) begin
            chk("access_penable", bus.penable, 1);
            chk("access_psel", bus.psel, 1);
            chk("access_paddr", bus.paddr, a);
            chk("access_gnt", bus.gnt, 2'b01 << w);
            bus.pready  = !tmo && (k == waits);
            bus.pslverr = bus.pready ? slverr : 1'($urandom);
            bus.prdata  = bus.pready ? rd : $urandom;
            step();
            k++;
        end
        chk("access_cycles", k, exp_acc);
        chk("done", bus.done, 2'b01 << w);
        chk("done_gnt", bus.gnt, 0);
        chk("done_psel", bus.psel, 0);
        chk("done_penable", bus.penable, 0);
        chk("paddr_hold", bus.paddr, a);
        chk("rsp_rdata", bus.rsp_rdata, (tmo || wr[w]) ? 32'h0 : rd);
        chk("rsp_err", bus.rsp_err, tmo ? 1'b1 : slverr);
        bus.pready = 1'($urandom);
        prev_done = 1'b1;
    endtask

    initial begin
        bus.req = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = '0;
        repeat (2) step();
        preset = 1'b0;
        chk_reset_vals("reset");
        xfer(2'b01, 2'b01, 64'h0, {32'h0, 32'hA5A5_0001} | 64'h0, 0, 1'b0, 32'h0);
        xfer(2'b10, 2'b00, {32'h0000_0010, 32'h0}, 64'h0, 3, 1'b0, 32'h0000_00FF);
        xfer(2'b01, 2'b00, {32'h0, 32'h0000_0004}, 64'h0, 0, 1'b1, 32'h1234_5678);
        for (int i = 0; i < 4; i++)
            xfer(2'b11, 2'b11, {$urandom, $urandom}, {$urandom, $urandom}, 0, 1'b0, 32'h0);
        xfer(2'b10, 2'b00, {$urandom, $urandom}, 64'h0, 7, 1'b0, $urandom);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                bus.req = 2'b00;
                step();
                chk("idle_gnt", bus.gnt, 0);
                chk("idle_psel", bus.psel, 0);
                step();
                prev_done = 1'b0;
            end
            xfer(2'($urandom_range(1, 3)), 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                 $urandom_range(0, 6), 1'($urandom), $urandom);
        end
        bus.req = 2'b01;
        bus.pready = 1'b0;
        repeat (4) step();
        chk("pre_reset_penable", bus.penable, 1);
        preset = 1'b1;
        step();
        preset = 1'b0;
        chk_reset_vals("midreset");
        last_w = 1'b1;
        prev_done = 1'b0;
        xfer(2'b11, 2'b00, {$urandom, $urandom}, 64'h0, 1, 1'b0, 32'hCAFE_F00D);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
